// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues one data-memory request at a time,
// then drives the register file write port and counts retired instructions.
//
// state      | meaning
// S_IDLE     | ready for a new instruction; non-memory ops go straight to WB
// S_MEM_WAIT | memory op issued from the held slot, waiting for dhit
module mem_wb_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          flush,
   input  logic          in_regwrite,
   input  logic [AW-1:0] in_wsel,
   input  logic [1:0]    in_wbsrc,
   input  logic          in_memread,
   input  logic          in_memwrite,
   input  logic [DW-1:0] in_alu_out,
   input  logic [DW-1:0] in_store_data,
   input  logic [DW-1:0] in_npc,
   input  logic [15:0]   in_imm16,
   output logic          dren,
   output logic          dwen,
   output logic [DW-1:0] daddr,
   output logic [DW-1:0] dstore,
   input  logic          dhit,
   input  logic [DW-1:0] dload,
   output logic          WEN,
   output logic [AW-1:0] wsel,
   output logic [DW-1:0] wdat,
   output logic [31:0]   retired
);

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_MEM_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_NPC  = 2'b10;
   localparam logic [1:0] SRC_LUI  = 2'b11;

   state_t        state_q, state_d;

   logic          slot_regwrite_q, slot_regwrite_d;
   logic [AW-1:0] slot_wsel_q,     slot_wsel_d;
   logic [1:0]    slot_wbsrc_q,    slot_wbsrc_d;
   logic          slot_memread_q,  slot_memread_d;
   logic          slot_memwrite_q, slot_memwrite_d;
   logic [DW-1:0] slot_addr_q,     slot_addr_d;
   logic [DW-1:0] slot_sdata_q,    slot_sdata_d;
   logic [DW-1:0] slot_npc_q,      slot_npc_d;
   logic [15:0]   slot_imm16_q,    slot_imm16_d;

   logic          wb_valid_q,    wb_valid_d;
   logic          wb_regwrite_q, wb_regwrite_d;
   logic [AW-1:0] wb_wsel_q,     wb_wsel_d;
   logic [DW-1:0] wb_wdat_q,     wb_wdat_d;

   logic [31:0]   retired_q;

   logic          accept;
   logic          mem_busy;

   // Code 01 only selects load data when the op actually went to memory.
   function automatic logic [DW-1:0] sel_wdat(
      input logic [1:0]    src,
      input logic          from_mem,
      input logic [DW-1:0] alu,
      input logic [DW-1:0] npc,
      input logic [DW-1:0] ld,
      input logic [15:0]   imm
   );
      logic [DW-1:0] res;
      res = alu;
      case (src)
         SRC_ALU:  res = alu;
         SRC_LOAD: res = from_mem ? ld : alu;
         SRC_NPC:  res = npc;
         SRC_LUI:  res = DW'({imm, 16'h0000});
         default:  res = alu;
      endcase
      return res;
   endfunction

   assign accept   = in_valid & ~flush;
   assign mem_busy = (state_q == S_MEM_WAIT);

   always_comb begin
      state_d         = state_q;
      slot_regwrite_d = slot_regwrite_q;
      slot_wsel_d     = slot_wsel_q;
      slot_wbsrc_d    = slot_wbsrc_q;
      slot_memread_d  = slot_memread_q;
      slot_memwrite_d = slot_memwrite_q;
      slot_addr_d     = slot_addr_q;
      slot_sdata_d    = slot_sdata_q;
      slot_npc_d      = slot_npc_q;
      slot_imm16_d    = slot_imm16_q;
      wb_valid_d      = 1'b0;
      wb_regwrite_d   = wb_regwrite_q;
      wb_wsel_d       = wb_wsel_q;
      wb_wdat_d       = wb_wdat_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (in_memread | in_memwrite) begin
                  slot_regwrite_d = in_regwrite;
                  slot_wsel_d     = in_wsel;
                  slot_wbsrc_d    = in_wbsrc;
                  slot_memread_d  = in_memread;
                  slot_memwrite_d = in_memwrite;
                  slot_addr_d     = in_alu_out;
                  slot_sdata_d    = in_store_data;
                  slot_npc_d      = in_npc;
                  slot_imm16_d    = in_imm16;
                  state_d         = S_MEM_WAIT;
               end else begin
                  wb_valid_d    = 1'b1;
                  wb_regwrite_d = in_regwrite;
                  wb_wsel_d     = in_wsel;
                  wb_wdat_d     = sel_wdat(in_wbsrc, 1'b0, in_alu_out, in_npc,
                                           dload, in_imm16);
               end
            end
         end
         S_MEM_WAIT: begin
            // An issued access is never aborted; in_valid/flush are ignored here.
            if (dhit) begin
               wb_valid_d    = 1'b1;
               wb_regwrite_d = slot_regwrite_q;
               wb_wsel_d     = slot_wsel_q;
               wb_wdat_d     = sel_wdat(slot_wbsrc_q, 1'b1, slot_addr_q,
                                        slot_npc_q, dload, slot_imm16_q);
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= S_IDLE;
         slot_regwrite_q <= 1'b0;
         slot_wsel_q     <= '0;
         slot_wbsrc_q    <= '0;
         slot_memread_q  <= 1'b0;
         slot_memwrite_q <= 1'b0;
         slot_addr_q     <= '0;
         slot_sdata_q    <= '0;
         slot_npc_q      <= '0;
         slot_imm16_q    <= '0;
         wb_valid_q      <= 1'b0;
         wb_regwrite_q   <= 1'b0;
         wb_wsel_q       <= '0;
         wb_wdat_q       <= '0;
      end else begin
         state_q         <= state_d;
         slot_regwrite_q <= slot_regwrite_d;
         slot_wsel_q     <= slot_wsel_d;
         slot_wbsrc_q    <= slot_wbsrc_d;
         slot_memread_q  <= slot_memread_d;
         slot_memwrite_q <= slot_memwrite_d;
         slot_addr_q     <= slot_addr_d;
         slot_sdata_q    <= slot_sdata_d;
         slot_npc_q      <= slot_npc_d;
         slot_imm16_q    <= slot_imm16_d;
         wb_valid_q      <= wb_valid_d;
         wb_regwrite_q   <= wb_regwrite_d;
         wb_wsel_q       <= wb_wsel_d;
         wb_wdat_q       <= wb_wdat_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         retired_q <= '0;
      end else if (wb_valid_q) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   // in_ready is gated by reset so upstream sees 0 while n_rst is low.
   assign in_ready = n_rst & (state_q == S_IDLE);

   assign dren   = mem_busy & slot_memread_q;
   assign dwen   = mem_busy & slot_memwrite_q;
   assign daddr  = mem_busy ? slot_addr_q  : '0;
   assign dstore = mem_busy ? slot_sdata_q : '0;

   // r0 writes are suppressed here as well as in the register file.
   assign WEN  = wb_valid_q & wb_regwrite_q & (wb_wsel_q != '0);
   assign wsel = wb_valid_q ? wb_wsel_q : '0;
   assign wdat = wb_valid_q ? wb_wdat_q : '0;

   assign retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

   logic        clk;
   logic        n_rst;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        in_regwrite;
   logic [4:0]  in_wsel;
   logic [1:0]  in_wbsrc;
   logic        in_memread;
   logic        in_memwrite;
   logic [31:0] in_alu_out;
   logic [31:0] in_store_data;
   logic [31:0] in_npc;
   logic [15:0] in_imm16;
   logic        dren;
   logic        dwen;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;
   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic [31:0] retired;

   int n_checks;
   int n_errors;
   int preset_cnt;

   mem_wb_stage #(.DW(32), .AW(5)) dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .in_regwrite(in_regwrite), .in_wsel(in_wsel), .in_wbsrc(in_wbsrc),
      .in_memread(in_memread), .in_memwrite(in_memwrite),
      .in_alu_out(in_alu_out), .in_store_data(in_store_data),
      .in_npc(in_npc), .in_imm16(in_imm16),
      .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .WEN(WEN), .wsel(wsel), .wdat(wdat), .retired(retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        rw;
      logic [4:0]  ws;
      logic [1:0]  src;
      logic        mr;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [31:0] npc;
      logic [15:0] imm;
   } instr_t;

   instr_t      pend_q[$];
   logic        m_wbv;
   logic        m_rw;
   logic [4:0]  m_ws;
   logic [31:0] m_wd;
   logic [31:0] m_ret;
   int          preset_seen;

   function automatic logic [31:0] wb_value(input instr_t i, input logic from_mem,
                                            input logic [31:0] ld);
      if (i.src == 2'b10) return i.npc;
      if (i.src == 2'b11) return {i.imm, 16'h0000};
      if (i.src == 2'b01 && from_mem) return ld;
      return i.alu;
   endfunction

   initial begin
      instr_t cur;
      instr_t p;
      logic   busy;
      pend_q.delete();
      m_wbv = 0; m_rw = 0; m_ws = 0; m_wd = 0; m_ret = 0; preset_seen = 0;
      forever begin
         @(posedge clk);
         if (!n_rst) begin
            pend_q.delete();
            m_wbv = 0; m_rw = 0; m_ws = 0; m_wd = 0; m_ret = 0;
            preset_seen = preset_cnt;
         end else begin
            if (preset_seen != preset_cnt) begin
               m_ret = 32'hFFFF_FFFF;
               preset_seen = preset_cnt;
            end
            if (m_wbv) m_ret = m_ret + 32'd1;
            cur = '{rw: in_regwrite, ws: in_wsel, src: in_wbsrc, mr: in_memread,
                    mw: in_memwrite, alu: in_alu_out, sd: in_store_data,
                    npc: in_npc, imm: in_imm16};
            m_wbv = 0;
            if (pend_q.size() == 0) begin
               if (in_valid && !flush) begin
                  if (cur.mr || cur.mw) begin
                     pend_q.push_back(cur);
                  end else begin
                     m_wbv = 1; m_rw = cur.rw; m_ws = cur.ws;
                     m_wd = wb_value(cur, 1'b0, 32'h0);
                  end
               end
            end else if (dhit) begin
               p = pend_q.pop_front();
               m_wbv = 1; m_rw = p.rw; m_ws = p.ws;
               m_wd = wb_value(p, 1'b1, dload);
            end
         end
         #1;
         if (n_rst) begin
            busy = (pend_q.size() != 0);
            check("model_in_ready", in_ready, !busy);
            check("model_dren",  dren,  busy ? pend_q[0].mr  : 1'b0);
            check("model_dwen",  dwen,  busy ? pend_q[0].mw  : 1'b0);
            if (busy) begin
               check("model_daddr",  daddr,  pend_q[0].alu);
               check("model_dstore", dstore, pend_q[0].sd);
            end
            check("model_WEN",  WEN,  m_wbv && m_rw && (m_ws != 0));
            check("model_wsel", wsel, m_wbv ? m_ws : 5'd0);
            check("model_wdat", wdat, m_wbv ? m_wd : 32'd0);
            check("model_retired", retired, m_ret);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_in();
      in_valid = 0; flush = 0; in_regwrite = 0; in_wsel = 0; in_wbsrc = 0;
      in_memread = 0; in_memwrite = 0; in_alu_out = 0; in_store_data = 0;
      in_npc = 0; in_imm16 = 0; dhit = 0; dload = 0;
   endtask

   task automatic put(input logic rw, input logic [4:0] ws, input logic [1:0] src,
                      input logic mr, input logic mw, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [31:0] npc,
                      input logic [15:0] imm);
      in_valid = 1; flush = 0; in_regwrite = rw; in_wsel = ws; in_wbsrc = src;
      in_memread = mr; in_memwrite = mw; in_alu_out = alu; in_store_data = sd;
      in_npc = npc; in_imm16 = imm;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; preset_cnt = 0;
      n_rst = 0;
      idle_in();
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_dren", dren, 0);
      check("rst_WEN", WEN, 0);
      check("rst_retired", retired, 0);
      repeat (2) @(negedge clk);
      n_rst = 1;
      #1 check("rel_in_ready", in_ready, 1);

      // ALU op
      @(negedge clk);
      put(1, 5'd5, 2'b00, 0, 0, 32'h2A, 0, 0, 0);
      @(negedge clk);
      idle_in();
      check("alu_WEN", WEN, 1);
      check("alu_wsel", wsel, 5);
      check("alu_wdat", wdat, 32'h2A);
      check("alu_ret0", retired, 0);
      @(negedge clk);
      check("alu_ret1", retired, 1);
      check("alu_WEN_drop", WEN, 0);

      // load with 3 wait cycles; junk offered meanwhile must be ignored
      put(1, 5'd8, 2'b01, 1, 0, 32'h100, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         put(1, 5'd9, 2'b00, 0, 0, 32'h77, 0, 0, 0);
         check("ld_dren", dren, 1);
         check("ld_daddr", daddr, 32'h100);
         check("ld_in_ready", in_ready, 0);
         check("ld_WEN_wait", WEN, 0);
      end
      dhit = 1; dload = 32'hDEAD_BEEF;
      @(negedge clk);
      idle_in();
      check("ld_WEN", WEN, 1);
      check("ld_wsel", wsel, 8);
      check("ld_wdat", wdat, 32'hDEAD_BEEF);
      check("ld_dren_off", dren, 0);
      check("ld_in_ready", in_ready, 1);
      @(negedge clk);
      check("ld_no_junk", WEN, 0);
      check("ld_ret", retired, 2);

      // store then flushed instruction
      put(0, 5'd0, 2'b00, 0, 1, 32'h40, 32'h1234, 0, 0);
      @(negedge clk);
      idle_in();
      check("st_dwen", dwen, 1);
      check("st_dstore", dstore, 32'h1234);
      check("st_daddr", daddr, 32'h40);
      @(negedge clk);
      check("st_dwen2", dwen, 1);
      check("st_WEN", WEN, 0);
      dhit = 1;
      @(negedge clk);
      idle_in();
      check("st_WEN_wb", WEN, 0);
      check("st_dwen_off", dwen, 0);
      @(negedge clk);
      check("st_ret", retired, 3);
      put(1, 5'd4, 2'b00, 0, 0, 32'h55, 0, 0, 0);
      flush = 1;
      @(negedge clk);
      idle_in();
      check("fl_WEN", WEN, 0);
      @(negedge clk);
      check("fl_ret", retired, 3);

      // LUI, JAL r31, JAL r0 back-to-back
      put(1, 5'd3, 2'b11, 0, 0, 0, 0, 0, 16'hBEEF);
      @(negedge clk);
      put(1, 5'd31, 2'b10, 0, 0, 0, 0, 32'h44, 0);
      check("lui_WEN", WEN, 1);
      check("lui_wsel", wsel, 3);
      check("lui_wdat", wdat, 32'hBEEF_0000);
      @(negedge clk);
      put(1, 5'd0, 2'b10, 0, 0, 0, 0, 32'h44, 0);
      check("jal_WEN", WEN, 1);
      check("jal_wsel", wsel, 31);
      check("jal_wdat", wdat, 32'h44);
      @(negedge clk);
      idle_in();
      check("r0_WEN", WEN, 0);
      check("r0_wdat", wdat, 32'h44);
      check("r0_ret", retired, 5);
      @(negedge clk);
      check("r0_ret2", retired, 6);

      // counter wrap
      @(negedge clk);
      force dut.retired_q = 32'hFFFF_FFFF;
      #1 release dut.retired_q;
      preset_cnt++;
      put(1, 5'd7, 2'b00, 0, 0, 32'h99, 0, 0, 0);
      @(negedge clk);
      idle_in();
      check("wrap_pre", retired, 32'hFFFF_FFFF);
      @(negedge clk);
      check("wrap_zero", retired, 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(negedge clk);
         r = int'($urandom_range(0, 9));
         put($urandom_range(0, 7) != 0, 5'($urandom), 2'($urandom),
             r < 2, (r == 2) || (r == 9 && $urandom_range(0, 1) == 1),
             $urandom, $urandom, $urandom, 16'($urandom));
         in_valid = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 7) == 0);
         dhit     = ($urandom_range(0, 2) == 0);
         dload    = $urandom;
      end

      // drain, then reset in the middle of a load
      @(negedge clk);
      idle_in();
      dhit = 1;
      repeat (2) @(negedge clk);
      idle_in();
      @(negedge clk);
      put(1, 5'd2, 2'b01, 1, 0, 32'h200, 0, 0, 0);
      @(negedge clk);
      idle_in();
      check("mid_dren", dren, 1);
      check("mid_ret_nz", retired != 0, 1);
      #2 n_rst = 0;
      #1;
      check("mid_rst_dren", dren, 0);
      check("mid_rst_WEN", WEN, 0);
      check("mid_rst_retired", retired, 0);
      check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      n_rst = 1;
      #1;
      check("mid_rel_in_ready", in_ready, 1);
      check("mid_rel_dren", dren, 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the pipelined datapath.
- Accepts one instruction at a time from the EX/MEM side and performs the data-memory request for loads and stores.
- Waits on the data-memory handshake, then drives the register file's single write port (WEN/wsel/wdat).
- Also exposes a retired-instruction counter for the test harness.

Parameters:
- DW, 32, datapath and register width.
- AW, 5, register select width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- n_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  discard the upstream instruction offered this cycle.
- in_regwrite  in  1  instruction writes a register.
- in_wsel  in  AW  destination register.
- in_wbsrc  in  2  write data source: 00 ALU, 01 load, 10 npc, 11 LUI.
- in_memread  in  1  load.
- in_memwrite  in  1  store.
- in_alu_out  in  DW  ALU result, also the memory address.
- in_store_data  in  DW  store data.
- in_npc  in  DW  PC+4 (link value).
- in_imm16  in  16  immediate for LUI.
- dren  out  1  data-memory read request.
- dwen  out  1  data-memory write request.
- daddr  out  DW  data-memory address.
- dstore  out  DW  data-memory write data.
- dhit  in  1  data-memory access complete this cycle.
- dload  in  DW  load data, valid when dhit.
- WEN  out  1  register file write enable.
- wsel  out  AW  register file write select.
- wdat  out  DW  register file write data.
- retired  out  32  count of instructions that completed writeback.

Behaviour:
- Reset (async, n_rst=0): state IDLE, wb_valid=0, held memory slot cleared.
  - All outputs 0 during and after reset: in_ready=0 while n_rst=0, 1 after.
  - dren/dwen drop immediately, even in the middle of a pending access; retired=0.
- Two-state FSM: IDLE, MEM_WAIT. in_ready = (state==IDLE).
- IDLE, accept = in_valid & ~flush:
  - Non-memory instruction: captured directly into the WB register at posedge (wb_valid=1). Write data is chosen by in_wbsrc:
    - ALU → in_alu_out.
    - npc → in_npc.
    - LUI → {in_imm16, 16'h0}.
    - Code 01 without memread is treated as ALU.
  - Memory instruction (memread or memwrite): fields captured into the memory slot, go to MEM_WAIT. wb_valid=0 the next cycle.
  - No accept: wb_valid=0 the next cycle.
  - dhit while in IDLE is ignored.
- MEM_WAIT:
  - dren=held memread, dwen=held memwrite. daddr and dstore come from the held slot and stay stable until dhit.
  - in_valid and flush are ignored: an issued memory op is never aborted.
  - On dhit: load the WB register and return to IDLE.
    - wdat = dload when wbsrc=01, otherwise per wbsrc from held fields.
    - A store retires with regwrite as captured, normally 0.
  - No dhit: remain in MEM_WAIT; wb_valid=0.
- WB register drives the register file write port:
  - WEN = wb_valid & wb_regwrite & (wb_wsel != 0). Writes to r0 are suppressed here as well as in the register file.
  - wsel = wb_wsel, wdat = wb_wdat. Both are 0 when wb_valid=0.
  - The register file latches on negedge, so a write is visible to readers in the second half of the same cycle.
- Latency:
  - Non-memory instruction: WEN high exactly 1 cycle after acceptance.
  - Memory instruction: WEN high the cycle after the dhit cycle.
  - Each retiring instruction holds wb_valid for exactly one cycle.
- retired increments by 1 on each posedge where wb_valid=1 (stores included). Wraps from 0xFFFFFFFF to 0.
- Simultaneous events:
  - dhit in the same cycle as in_valid: in_valid is not accepted, because in_ready=0. The new instruction can be accepted the following cycle.
  - Back-to-back non-memory instructions sustain one per cycle.

Test Plan:
- Reset mid-access: load in MEM_WAIT with dren=1, pulse n_rst low → dren, WEN, retired all 0 immediately; in_ready=1 after release.
- ALU op: in_valid, regwrite=1, wsel=5, wbsrc=00, alu_out=0x0000002A → next cycle WEN=1, wsel=5, wdat=0x2A; retired=1 the cycle after.
- Load with 3 wait cycles: memread, alu_out=0x100, wsel=8 → dren=1, daddr=0x100 held 3 cycles with in_ready=0. dhit with dload=0xDEADBEEF → next cycle WEN=1, wsel=8, wdat=0xDEADBEEF.
- Store, then flush of the next instruction:
  - Store: memwrite, addr 0x40, data 0x1234 → dwen=1, dstore=0x1234 until dhit; WEN stays 0.
  - Flushed instruction (flush=1 in IDLE) → not captured, retired unchanged.
- LUI and JAL to r0/r31:
  - wbsrc=11, imm16=0xBEEF, wsel=3 → wdat=0xBEEF0000.
  - wbsrc=10, npc=0x44, wsel=31 → wdat=0x44.
  - Same instruction with wsel=0 → WEN=0 but retired increments.
- Counter wrap: force retired to 0xFFFFFFFF via 2^32 retirements or a forced state, retire one → retired=0.
